// File: rtl/alu_result_stage.sv
// Result stage behind the adder: derives N/Z/C/V for each accepted sum and
// buffers result+flags in a small FIFO toward a possibly stalling consumer.
module alu_result_stage #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           a_i,
  input  logic [WIDTH-1:0]           b_i,
  input  logic [WIDTH-1:0]           sum,
  input  logic                       carry,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           res_o,
  output logic [3:0]                 flags_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] res_mem [DEPTH];
  logic [3:0]       flg_mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;
  logic [3:0]       flags_new;

  // in_ready comes only from registered count, so a pop never frees a slot
  // for a push in the same cycle.
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign flags_new[3] = sum[WIDTH-1];
  assign flags_new[2] = (sum == '0);
  assign flags_new[1] = carry;
  assign flags_new[0] = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        res_mem[i] <= '0;
        flg_mem[i] <= '0;
      end
    end else if (push) begin
      res_mem[wr_ptr] <= sum;
      flg_mem[wr_ptr] <= flags_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + PW'(1);
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);
    end
  end

  assign res_o   = res_mem[rd_ptr];
  assign flags_o = flg_mem[rd_ptr];
  assign count_o = count;

endmodule
